// File: rtl/fdiv_if.sv
// fdiv_if: start/done handshake and operand/result bus of the sequential divider
interface fdiv_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] result;
  logic        done;
  logic        busy;
  logic        div_by_zero;
  modport master (output start, a, b, input result, done, busy, div_by_zero);
  modport slave (input start, a, b, output result, done, busy, div_by_zero);
endinterface

// File: rtl/fdiv_seq.sv
// fdiv_seq: sequential binary16 divider, 13-step restoring mantissa division behind start/done
module fdiv_seq #(
  parameter logic [14:0] ONE  = 15'h3C00,
  parameter int          BIAS = 15,
  parameter int          ITER = 13
) (
  input logic   clk,
  input logic   rst_n,
  fdiv_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;
  state_t state, state_nx;
  logic              sign, ge, special, sp_dbz, guard, dbz_q;
  logic signed [6:0] e, e_n;
  logic [4:0]        ea, eb;
  logic [9:0]        mant;
  logic [10:0]       m2, rnd;
  logic [11:0]       r, r_sub;
  logic [12:0]       q;
  logic [3:0]        cnt;
  logic [15:0]       sp_res, norm_res, res_q;
  always_comb begin
    ea = bus.a[14:10];
    eb = bus.b[14:10];
    special = ea == 5'd0 || eb == 5'd0 || bus.b[14:0] == ONE;
    sp_dbz = ea != 5'd0 && eb == 5'd0;
    sp_res = ea == 5'd0 ? 16'h0000 :
             eb == 5'd0 ? {bus.a[15] ^ bus.b[15], 5'h1F, 10'h0} : {bus.a[15] ^ bus.b[15], bus.a[14:0]};
    ge = r >= {1'b0, m2};
    r_sub = ge ? r - {1'b0, m2} : r;
    mant = q[12] ? q[11:2] : q[10:1];
    guard = q[12] ? q[1] : q[0];
    rnd = {1'b0, mant} + {10'd0, guard};
    // a rounding carry leaves rnd[9:0] at zero, which is exactly the wrapped mantissa
    e_n = e - (q[12] ? 7'sd0 : 7'sd1) + (rnd[10] ? 7'sd1 : 7'sd0);
    norm_res = e_n >= 7'sd31 ? {sign, 5'h1F, 10'h0} :
               e_n <= 7'sd0 ? 16'h0000 : {sign, e_n[4:0], rnd[9:0]};
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.start ? (special ? DONE : CALC) : IDLE;
      CALC:    state_nx = cnt == 4'(ITER - 1) ? NORM : CALC;
      NORM:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign  <= 1'b0;
      e     <= '0;
      m2    <= '0;
      r     <= '0;
      q     <= '0;
      cnt   <= '0;
      res_q <= '0;
      dbz_q <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      sign <= bus.a[15] ^ bus.b[15];
      e    <= {2'b00, ea} - {2'b00, eb} + 7'(BIAS);
      m2   <= {1'b1, bus.b[9:0]};
      r    <= {2'b01, bus.a[9:0]};
      q    <= '0;
      cnt  <= '0;
      if (special) begin
        res_q <= sp_res;
        dbz_q <= sp_dbz;
      end
    end else if (state == CALC) begin
      r   <= r_sub << 1;
      q   <= {q[11:0], ge};
      cnt <= cnt + 4'd1;
    end else if (state == NORM) begin
      res_q <= norm_res;
      dbz_q <= 1'b0;
    end
  end
  assign bus.result      = res_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.done        = state == DONE;
  assign bus.busy        = state != IDLE;
endmodule

// File: tb/tb_fdiv_seq.sv
// tb_fdiv_seq: directed and random division checked every cycle against an arithmetic reference model
module tb_fdiv_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  fdiv_if bus ();
  fdiv_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int tests = 0, fails = 0, cyc = 0, t_n = -1000, done_k = 0, k;
  logic [15:0] old_res = 16'h0, new_res = 16'h0, ra, rb;
  logic old_dbz = 1'b0, new_dbz = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // quotient mantissa as an integer division, then normalise/round/range-check
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic d, output int lat);
    int m1, m2, q, e, mant, g;
    logic s;
    s = a[15] ^ b[15];
    d = 1'b0;
    lat = 0;
    if (a[14:10] == 5'd0) r = 16'h0000;
    else if (b[14:10] == 5'd0) begin
      r = {s, 15'h7C00};
      d = 1'b1;
    end else if (b[14:0] == 15'h3C00) r = {s, a[14:0]};
    else begin
      lat = 14;
      m1 = 1024 + int'(a[9:0]);
      m2 = 1024 + int'(b[9:0]);
      q = (m1 * 4096) / m2;
      e = int'(a[14:10]) - int'(b[14:10]) + 15;
      if (q >= 4096) begin
        mant = (q / 4) % 1024;
        g = (q / 2) % 2;
      end else begin
        mant = (q / 2) % 1024;
        g = q % 2;
        e = e - 1;
      end
      mant = mant + g;
      if (mant == 1024) begin
        mant = 0;
        e = e + 1;
      end
      if (e >= 31) r = {s, 15'h7C00};
      else if (e <= 0) r = 16'h0000;
      else r = {s, 5'(e), 10'(mant)};
    end
  endfunction

  always @(negedge clk) if (rst_n) begin
    k = cyc - t_n;
    chk("done", 32'(bus.done), 32'(k == done_k));
    chk("busy", 32'(bus.busy), 32'(k >= 0 && k <= done_k));
    chk("result", 32'(bus.result), 32'(k >= done_k ? new_res : old_res));
    chk("div_by_zero", 32'(bus.div_by_zero), 32'(k >= done_k ? new_dbz : old_dbz));
  end

  task automatic accept(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic d;
    int lat;
    model(a, b, r, d, lat);
    @(negedge clk);
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    old_res = new_res;
    old_dbz = new_dbz;
    new_res = r;
    new_dbz = d;
    done_k = lat;
    t_n = cyc;
    bus.start = 1'b0;
    bus.a = 16'($urandom);
    bus.b = 16'($urandom);
  endtask

  task automatic op(input logic [15:0] a, input logic [15:0] b, input int gap, input int glitch);
    accept(a, b);
    for (int i = 0; i <= done_k + gap; i++) begin
      @(negedge clk);
      bus.start = (i == glitch);
      if (i == glitch) begin
        bus.a = 16'h7BFF;
        bus.b = 16'h0000;
      end
    end
  endtask

  task automatic dir(input logic [15:0] a, input logic [15:0] b, input logic [15:0] er,
                     input logic ed, input int glitch);
    op(a, b, 0, glitch);
    chk("directed_result", 32'(bus.result), 32'(er));
    chk("directed_dbz", 32'(bus.div_by_zero), 32'(ed));
  endtask

  task automatic pin(input logic [15:0] a, input logic [15:0] b, input logic [15:0] er, input logic ed);
    logic [15:0] r;
    logic d;
    int lat;
    model(a, b, r, d, lat);
    chk("model_result", 32'(r), 32'(er));
    chk("model_dbz", 32'(d), 32'(ed));
  endtask

  task automatic reset_outputs_zero();
    chk("reset_result", 32'(bus.result), 32'h0);
    chk("reset_done", 32'(bus.done), 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    chk("reset_dbz", 32'(bus.div_by_zero), 32'h0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a = 16'h0;
    bus.b = 16'h0;
    #1 rst_n = 1'b0;
    #1 reset_outputs_zero();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    pin(16'h4400, 16'h4000, 16'h4000, 1'b0);
    pin(16'h3C00, 16'h4200, 16'h3555, 1'b0);
    pin(16'hC500, 16'h3C00, 16'hC500, 1'b0);
    pin(16'h4000, 16'h0000, 16'h7C00, 1'b1);
    pin(16'hC000, 16'h0000, 16'hFC00, 1'b1);
    pin(16'h7800, 16'h0400, 16'h7C00, 1'b0);
    pin(16'h0400, 16'h7800, 16'h0000, 1'b0);
    dir(16'h4400, 16'h4000, 16'h4000, 1'b0, -1);
    dir(16'h3C00, 16'h4200, 16'h3555, 1'b0, 5);
    dir(16'hC500, 16'h3C00, 16'hC500, 1'b0, -1);
    dir(16'h0000, 16'h4000, 16'h0000, 1'b0, -1);
    dir(16'h4000, 16'h0000, 16'h7C00, 1'b1, -1);
    dir(16'hC000, 16'h0000, 16'hFC00, 1'b1, -1);
    dir(16'h7800, 16'h0400, 16'h7C00, 1'b0, -1);
    dir(16'h0400, 16'h7800, 16'h0000, 1'b0, -1);
    accept(16'h4400, 16'h4000);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 reset_outputs_zero();
    old_res = 16'h0;
    new_res = 16'h0;
    old_dbz = 1'b0;
    new_dbz = 1'b0;
    done_k = 0;
    t_n = -1000;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    dir(16'h4600, 16'h4000, 16'h4200, 1'b0, -1);
    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 7))
        0: ra[14:10] = 5'd0;
        1: rb[14:10] = 5'd0;
        2: rb[14:0] = 15'h3C00;
        default: ;
      endcase
      op(ra, rb, int'($urandom_range(0, 2)), -1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
